// File: rtl/ikm_pkg.sv
// rtl/ikm_pkg.sv - shared constants, angle table and state type for the IK base solver
package ikm_pkg;

  localparam int ANGLE_W         = 32;
  localparam int BASE_HEIGHT_DEF = 290;
  // Fractional bits below the integer datapath; without them truncation in the
  // micro-rotations swamps the angle for poses of only a few hundred units.
  localparam int FRAC_W          = 24;
  localparam int ITW             = 5;

  localparam logic [15:0]        CORDIC_INV_GAIN_Q16 = 16'd39797;
  localparam logic [ANGLE_W-1:0] ANGLE_HALF          = 32'h8000_0000;

  // round(atan(2^-i) * 2^32 / (2*pi))
  localparam logic [ANGLE_W-1:0] ATAN [0:29] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROTATE = 2'd1,
    ST_SCALE  = 2'd2,
    ST_DONE   = 2'd3
  } ikm_state_t;

endpackage

// File: rtl/ikm_base_solver_if.sv
// rtl/ikm_base_solver_if.sv - pose in / base-joint result out handshake bundle
interface ikm_base_solver_if #(
  parameter int IW = 32
);
  import ikm_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic signed [IW-1:0]   pos_x;
  logic signed [IW-1:0]   pos_y;
  logic signed [IW-1:0]   pos_z;
  logic                   out_valid;
  logic                   out_ready;
  logic [ANGLE_W-1:0]     jnt0;
  logic [31:0]            reach;
  logic signed [IW-1:0]   height;

  modport master (
    output in_valid, pos_x, pos_y, pos_z, out_ready,
    input  in_ready, out_valid, jnt0, reach, height
  );

  modport slave (
    input  in_valid, pos_x, pos_y, pos_z, out_ready,
    output in_ready, out_valid, jnt0, reach, height
  );

endinterface

// File: rtl/ikm_cordic_vec.sv
// rtl/ikm_cordic_vec.sv - vectoring CORDIC datapath, one micro-rotation per clock
module ikm_cordic_vec
  import ikm_pkg::*;
#(
  parameter int ITER = 24,
  parameter int DW   = 59
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic                  i_run,
  input  logic signed [DW-1:0]  i_x,
  input  logic signed [DW-1:0]  i_y,
  input  logic [ANGLE_W-1:0]    i_a,
  output logic                  o_last,
  output logic signed [DW-1:0]  o_x,
  output logic [ANGLE_W-1:0]    o_a
);

  logic signed [DW-1:0] r_x;
  logic signed [DW-1:0] r_y;
  logic [ANGLE_W-1:0]   r_a;
  logic [ITW-1:0]       r_iter;

  logic signed [DW-1:0] w_x_sh;
  logic signed [DW-1:0] w_y_sh;
  logic [ANGLE_W-1:0]   w_atan;

  assign w_x_sh = r_x >>> r_iter;
  assign w_y_sh = r_y >>> r_iter;
  assign w_atan = ATAN[r_iter];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x    <= '0;
      r_y    <= '0;
      r_a    <= '0;
      r_iter <= '0;
    end else if (i_load) begin
      r_x    <= i_x;
      r_y    <= i_y;
      r_a    <= i_a;
      r_iter <= '0;
    end else if (i_run) begin
      // Drive Y toward zero; both updates use the pre-edge X/Y.
      if (!r_y[DW-1]) begin
        r_x <= r_x + w_y_sh;
        r_y <= r_y - w_x_sh;
        r_a <= r_a + w_atan;
      end else begin
        r_x <= r_x - w_y_sh;
        r_y <= r_y + w_x_sh;
        r_a <= r_a - w_atan;
      end
      r_iter <= r_iter + 1'b1;
    end
  end

  assign o_last = (r_iter == ITW'(ITER - 1));
  assign o_x    = r_x;
  assign o_a    = r_a;

endmodule

// File: rtl/ikm_base_solver.sv
// rtl/ikm_base_solver.sv - base joint angle, planar reach and shoulder height from an end-effector position
module ikm_base_solver
  import ikm_pkg::*;
#(
  parameter int ITER        = 24,
  parameter int BASE_HEIGHT = BASE_HEIGHT_DEF,
  parameter int IW          = 32,
  parameter int GW          = 3
) (
  input  logic              clk,
  input  logic              reset,
  ikm_base_solver_if.slave  bus
);

  localparam int DW = IW + GW + FRAC_W;
  localparam int PW = DW + 16;

  ikm_state_t r_state;
  ikm_state_t w_next;
  logic       w_load;
  logic       w_run;
  logic       w_last;

  logic [ANGLE_W-1:0]  r_jnt0;
  logic [31:0]         r_reach;
  logic signed [IW-1:0] r_height;
  logic                r_zero;

  logic signed [DW-1:0] w_x_ext;
  logic signed [DW-1:0] w_z_ext;
  logic signed [DW-1:0] w_x0;
  logic signed [DW-1:0] w_y0;
  logic [ANGLE_W-1:0]   w_a0;
  logic signed [IW:0]   w_hdiff;
  logic signed [IW-1:0] w_height_sat;
  logic signed [DW-1:0] w_cx;
  logic [ANGLE_W-1:0]   w_ca;
  logic [PW-1:0]        w_prod;
  logic [PW-1:0]        w_prod_sh;
  logic [31:0]          w_reach_sat;

  // Quadrant pre-rotation folds z<0 into the right half-plane CORDIC covers.
  assign w_x_ext = {{GW{bus.pos_x[IW-1]}}, bus.pos_x, {FRAC_W{1'b0}}};
  assign w_z_ext = {{GW{bus.pos_z[IW-1]}}, bus.pos_z, {FRAC_W{1'b0}}};
  assign w_x0    = bus.pos_z[IW-1] ? -w_z_ext : w_z_ext;
  assign w_y0    = bus.pos_z[IW-1] ? -w_x_ext : w_x_ext;
  assign w_a0    = bus.pos_z[IW-1] ? ANGLE_HALF : '0;

  assign w_hdiff = {bus.pos_y[IW-1], bus.pos_y} - (IW+1)'(BASE_HEIGHT);

  always_comb begin
    w_height_sat = w_hdiff[IW-1:0];
    if (w_hdiff[IW] != w_hdiff[IW-1])
      w_height_sat = w_hdiff[IW] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
  end

  ikm_cordic_vec #(
    .ITER (ITER),
    .DW   (DW)
  ) u_cordic (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_run  (w_run),
    .i_x    (w_x0),
    .i_y    (w_y0),
    .i_a    (w_a0),
    .o_last (w_last),
    .o_x    (w_cx),
    .o_a    (w_ca)
  );

  // X is never negative after pre-rotation, so an unsigned product is exact.
  assign w_prod      = PW'($unsigned(w_cx)) * PW'(CORDIC_INV_GAIN_Q16);
  assign w_prod_sh   = w_prod >> (16 + FRAC_W);
  assign w_reach_sat = (w_prod_sh > PW'(32'hFFFF_FFFF)) ? 32'hFFFF_FFFF : w_prod_sh[31:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_run  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_load = 1'b1;
          w_next = ST_ROTATE;
        end
      end
      ST_ROTATE: begin
        w_run = 1'b1;
        if (w_last) w_next = ST_SCALE;
      end
      ST_SCALE: w_next = ST_DONE;
      ST_DONE:  if (bus.out_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_jnt0   <= '0;
      r_reach  <= '0;
      r_height <= '0;
      r_zero   <= 1'b0;
    end else begin
      if (w_load) begin
        r_height <= w_height_sat;
        r_zero   <= (bus.pos_x == '0) && (bus.pos_z == '0);
      end
      // The origin has no direction; CORDIC would otherwise sum every ATAN entry.
      if (r_state == ST_SCALE) begin
        r_reach <= w_reach_sat;
        r_jnt0  <= r_zero ? '0 : w_ca;
      end
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.jnt0      = r_jnt0;
  assign bus.reach     = r_reach;
  assign bus.height    = r_height;

endmodule

// File: tb/tb_ikm_base_solver.sv
// tb/tb_ikm_base_solver.sv - scoreboard bench for ikm_base_solver against a real-valued atan2/hypot model
module tb_ikm_base_solver;
  import ikm_pkg::*;

  localparam int  ITER  = 24;
  localparam int  IW    = 32;
  localparam real PI    = 3.14159265358979323846;
  localparam real TWO32 = 4294967296.0;

  typedef struct {
    real ang;
    real r;
    int  h;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  int     n_cmp = 0;
  int     n_err = 0;
  longint cyc = 0;
  exp_t   sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ikm_base_solver_if #(.IW(IW)) bus();

  ikm_base_solver #(
    .ITER        (ITER),
    .BASE_HEIGHT (290),
    .IW          (IW),
    .GW          (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic exp_t model(input int x, input int y, input int z);
    exp_t   e;
    longint d;
    e.ang = $atan2(real'(x), real'(z)) * TWO32 / (2.0 * PI);
    if (e.ang < 0.0) e.ang = e.ang + TWO32;
    e.r = $sqrt(real'(x) * real'(x) + real'(z) * real'(z));
    d = longint'(y) - 64'sd290;
    if (d < -64'sd2147483648) d = -64'sd2147483648;
    if (d > 64'sd2147483647)  d = 64'sd2147483647;
    e.h = int'(d);
    return e;
  endfunction

  function automatic real ang_err(input logic [31:0] j, input real e);
    real d;
    d = real'(longint'({32'b0, j})) - e;
    if (d > TWO32 / 2.0)       d = d - TWO32;
    else if (d < -TWO32 / 2.0) d = d + TWO32;
    return (d < 0.0) ? -d : d;
  endfunction

  function automatic real reach_err(input logic [31:0] r, input real e);
    real d;
    d = real'(longint'({32'b0, r})) - e;
    return (d < 0.0) ? -d : d;
  endfunction

  task automatic drive_pose(input int x, input int y, input int z, output longint acc);
    sb.push_back(model(x, y, z));
    bus.pos_x    = x;
    bus.pos_y    = y;
    bus.pos_z    = z;
    bus.in_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 100; k++) begin
      if (bus.in_ready) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 100 clocks");
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_result(output longint t, output logic [31:0] j, output logic [31:0] r,
                             output int h);
    t = -1;
    for (int k = 0; k < 200; k++) begin
      if (bus.out_valid) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    j = bus.jnt0;
    r = bus.reach;
    h = bus.height;
    if (t < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL result_timeout: out_valid stayed 0, required 1 within 200 clocks");
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    n_cmp++;
    if ({bus.jnt0, bus.reach, bus.height} !== 96'd0) begin
      n_err++;
      $display("FAIL reset_outputs: jnt0=%h reach=%0d height=%0d want all 0",
               bus.jnt0, bus.reach, bus.height);
    end
  endtask

  task automatic test_directed();
    int tbl [9][3];
    longint acc, t;
    logic [31:0] j, r;
    int h;
    exp_t e;
    tbl = '{'{0, 290, 1000}, '{1000, 0, 0}, '{-1000, 1290, -1000}, '{0, 0, 0},
            '{0, 290, -500}, '{32'sh8000_0000, 0, 32'sh8000_0000},
            '{32'sh7FFF_FFFF, 32'sh8000_0000, 32'sh7FFF_FFFF},
            '{-1000, 100, 0}, '{3, 32'sh7FFF_FFFF, -7}};
    for (int n = 0; n < 9; n++) begin
      drive_pose(tbl[n][0], tbl[n][1], tbl[n][2], acc);
      wait_result(t, j, r, h);
      release_result();
      e = sb.pop_front();
      n_cmp++;
      if (t - acc !== longint'(ITER + 2)) begin
        n_err++; $display("FAIL dir%0d_latency: got %0d want %0d", n, t - acc, ITER + 2);
      end
      n_cmp++;
      if (ang_err(j, e.ang) > 256.0) begin
        n_err++; $display("FAIL dir%0d_jnt0: got %h want %f +-256", n, j, e.ang);
      end
      n_cmp++;
      if (reach_err(r, e.r) > 2.0 + e.r / 16384.0) begin
        n_err++; $display("FAIL dir%0d_reach: got %0d want %f", n, r, e.r);
      end
      n_cmp++;
      if (h !== e.h) begin
        n_err++; $display("FAIL dir%0d_height: got %0d want %0d", n, h, e.h);
      end
    end
  endtask

  task automatic test_back_to_back();
    longint acc0, acc1, t;
    logic [31:0] j, r;
    int h;
    exp_t e;
    drive_pose(700, 10, 700, acc0);
    wait_result(t, j, r, h);
    release_result();
    e = sb.pop_front();
    drive_pose(-300, 20, 400, acc1);
    n_cmp++;
    if (acc1 - acc0 !== longint'(ITER + 3)) begin
      n_err++; $display("FAIL b2b_period: got %0d want %0d", acc1 - acc0, ITER + 3);
    end
    n_cmp++;
    if (ang_err(j, e.ang) > 256.0) begin
      n_err++; $display("FAIL b2b_first_jnt0: got %h want %f", j, e.ang);
    end
    wait_result(t, j, r, h);
    release_result();
    e = sb.pop_front();
    n_cmp++;
    if (ang_err(j, e.ang) > 256.0 || reach_err(r, e.r) > 2.0 + e.r / 16384.0) begin
      n_err++; $display("FAIL b2b_second: jnt0=%h reach=%0d want %f / %f", j, r, e.ang, e.r);
    end
  endtask

  task automatic test_backpressure();
    longint acc, t;
    logic [31:0] sj, sr;
    int sh;
    exp_t e;
    drive_pose(1000, 500, 1000, acc);
    wait_result(t, sj, sr, sh);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        bus.pos_x = 5; bus.pos_y = 5; bus.pos_z = 5; bus.in_valid = 1'b1;
      end
      if (k == 4) bus.in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({bus.out_valid, bus.in_ready, bus.jnt0, bus.reach, bus.height} !==
          {1'b1, 1'b0, sj, sr, sh}) begin
        n_err++;
        $display("FAIL bp_hold%0d: valid=%b ready=%b jnt0=%h reach=%0d h=%0d want 1 0 %h %0d %0d",
                 k, bus.out_valid, bus.in_ready, bus.jnt0, bus.reach, bus.height, sj, sr, sh);
      end
    end
    release_result();
    n_cmp++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      n_err++; $display("FAIL bp_release: ready=%b valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_pulse_ignored: in_ready=%b want 1", bus.in_ready);
    end
    e = sb.pop_front();
    n_cmp++;
    if (ang_err(sj, e.ang) > 256.0 || reach_err(sr, e.r) > 2.0 + e.r / 16384.0 || sh !== e.h) begin
      n_err++; $display("FAIL bp_result: jnt0=%h reach=%0d h=%0d want %f %f %0d",
                        sj, sr, sh, e.ang, e.r, e.h);
    end
  endtask

  task automatic test_reset_mid();
    longint acc, t;
    logic [31:0] j, r;
    int h, seen;
    exp_t e;
    drive_pose(400, 1290, 300, acc);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.jnt0, bus.reach, bus.height} !== {2'b10, 96'd0}) begin
      n_err++;
      $display("FAIL rst_mid_state: ready=%b valid=%b jnt0=%h reach=%0d h=%0d want 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.jnt0, bus.reach, bus.height);
    end
    e = sb.pop_back();
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < ITER + 4; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++; $display("FAIL rst_mid_no_output: out_valid cycles=%0d want 0", seen);
    end
    drive_pose(300, 0, 400, acc);
    wait_result(t, j, r, h);
    release_result();
    e = sb.pop_front();
    n_cmp++;
    if (t - acc !== longint'(ITER + 2)) begin
      n_err++; $display("FAIL rst_mid_latency: got %0d want %0d", t - acc, ITER + 2);
    end
    n_cmp++;
    if (ang_err(j, e.ang) > 256.0 || reach_err(r, e.r) > 2.0 + e.r / 16384.0 || h !== e.h) begin
      n_err++; $display("FAIL rst_mid_result: jnt0=%h reach=%0d h=%0d want %f %f %0d",
                        j, r, h, e.ang, e.r, e.h);
    end
  endtask

  task automatic test_random_sweep();
    longint acc, t;
    logic [31:0] j, r;
    int h, x, y, z;
    exp_t e;
    for (int n = 0; n < 1000; n++) begin
      x = int'($urandom_range(32'h7FFF_FFFE, 0)) - 32'sh3FFF_FFFF;
      z = int'($urandom_range(32'h7FFF_FFFE, 0)) - 32'sh3FFF_FFFF;
      y = int'($urandom);
      drive_pose(x, y, z, acc);
      wait_result(t, j, r, h);
      release_result();
      e = sb.pop_front();
      n_cmp++;
      if (ang_err(j, e.ang) > 256.0) begin
        n_err++; $display("FAIL rnd%0d_jnt0: x=%0d z=%0d got %h want %f", n, x, z, j, e.ang);
      end
      n_cmp++;
      if (reach_err(r, e.r) > 2.0 + e.r / 16384.0) begin
        n_err++; $display("FAIL rnd%0d_reach: x=%0d z=%0d got %0d want %f", n, x, z, r, e.r);
      end
      n_cmp++;
      if (h !== e.h) begin
        n_err++; $display("FAIL rnd%0d_height: y=%0d got %0d want %0d", n, y, h, e.h);
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.pos_x     = '0;
    bus.pos_y     = '0;
    bus.pos_z     = '0;
    reset         = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
